// File: rtl/multi_cycle_mul_pkg.sv
// Shared constants and encodings for the iterative RV64M multiplier.
package multi_cycle_mul_pkg;

  localparam int MUL_XLEN  = 64;
  localparam int MUL_LAT64 = 66;
  localparam int MUL_LAT32 = 34;

  // Full-width product bus handed back to the EXU.
  typedef logic [2*MUL_XLEN-1:0] mul_bus_t;

  // Operand signedness: bit1 = rs1 signed, bit0 = rs2 signed.
  typedef enum logic [1:0] {
    MUL_SIGNED_UU = 2'b00,
    MUL_SIGNED_SU = 2'b10,
    MUL_SIGNED_SS = 2'b11
  } mul_signed_e;

endpackage

// File: rtl/multi_cycle_mul.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU/MULW.
// One 66-bit add/sub per cycle. The product register is {acc[65:0], mplier[64:0]}.
// The final step subtracts, because the top multiplier bit carries negative weight.
module multi_cycle_mul
  import multi_cycle_mul_pkg::*;
#(
  parameter int XLEN      = MUL_XLEN,
  parameter int MUL_LAT64 = multi_cycle_mul_pkg::MUL_LAT64,
  parameter int MUL_LAT32 = multi_cycle_mul_pkg::MUL_LAT32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [1:0]        mul_signed,
  input  logic              mul_32,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic              ready,
  output logic [2*XLEN-1:0] mul_result
);

  localparam int OPW  = XLEN + 1;        // extended operand
  localparam int ACCW = XLEN + 2;        // accumulator / adder width
  localparam int PW   = ACCW + OPW;      // product register
  localparam int HW   = XLEN / 2;
  localparam int CW   = $clog2(MUL_LAT64 + 1);

  logic [CW-1:0]   counter;
  logic [OPW-1:0]  mcand_q;
  logic            m32_q;
  logic [PW-1:0]   prod_q;

  logic [OPW-1:0]  mcand_ext, mplier_ext;
  logic            zero_op, idle, done, last_step, fast;
  logic [ACCW-1:0] acc, addend, sum;
  logic [PW-1:0]   prod_next;

  // Extend both operands to 65 bits; MULW extends from bit 31.
  always_comb begin
    mcand_ext  = '0;
    mplier_ext = '0;
    if (mul_32) begin
      mcand_ext  = {{(OPW-HW){mul_signed[1] & rs1_data[HW-1]}}, rs1_data[HW-1:0]};
      mplier_ext = {{(OPW-HW){mul_signed[0] & rs2_data[HW-1]}}, rs2_data[HW-1:0]};
    end else begin
      mcand_ext  = {mul_signed[1] & rs1_data[XLEN-1], rs1_data};
      mplier_ext = {mul_signed[0] & rs2_data[XLEN-1], rs2_data};
    end
  end

  assign zero_op   = (mcand_ext == '0) || (mplier_ext == '0);
  assign idle      = (counter == '0);
  assign last_step = counter == (m32_q ? CW'(MUL_LAT32 - 1) : CW'(MUL_LAT64 - 1));
  assign done      = counter == (m32_q ? CW'(MUL_LAT32) : CW'(MUL_LAT64));
  assign fast      = valid && idle && zero_op;
  assign ready     = fast || (valid && done);

  // Shared add/sub: add the multiplicand when P[0] is set, subtracting on the last step.
  always_comb begin
    acc    = prod_q[PW-1:OPW];
    addend = '0;
    if (prod_q[0])
      addend = {mcand_q[OPW-1], mcand_q} ^ {ACCW{last_step}};
    sum       = acc + addend + ACCW'(prod_q[0] & last_step);
    prod_next = {sum[ACCW-1], sum, prod_q[OPW-1:1]};
  end

  // Accept, step and done sequencing; everything freezes while valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
      mcand_q <= '0;
      m32_q   <= 1'b0;
      prod_q  <= '0;
    end else if (valid) begin
      if (idle) begin
        if (!zero_op) begin
          mcand_q <= mcand_ext;
          m32_q   <= mul_32;
          prod_q  <= {{ACCW{1'b0}}, mplier_ext};
          counter <= CW'(1);
        end
      end else if (done) begin
        counter <= '0;
      end else begin
        prod_q  <= prod_next;
        counter <= counter + CW'(1);
      end
    end
  end

  // After only 33 shifts the MULW product sits HW bits higher than the 64-bit case.
  always_comb begin
    mul_result = '0;
    if (!fast) begin
      if (m32_q)
        mul_result = {{XLEN{1'b0}}, {HW{prod_q[XLEN-1]}}, prod_q[XLEN-1:HW]};
      else
        mul_result = prod_q[2*XLEN-1:0];
    end
  end

endmodule

// File: tb/tb_multi_cycle_mul.sv
// Directed bench for multi_cycle_mul: table of vectors plus stall/reset sequences.
module tb_multi_cycle_mul;
  import multi_cycle_mul_pkg::*;

  logic         clk = 1'b0;
  logic         rst, valid, mul_32;
  logic [1:0]   mul_signed;
  logic [63:0]  rs1_data, rs2_data;
  logic         ready;
  logic [127:0] mul_result;

  int checks = 0;
  int errors = 0;

  multi_cycle_mul dut (
    .clk(clk), .rst(rst), .valid(valid), .mul_signed(mul_signed), .mul_32(mul_32),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .ready(ready), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [63:0]  a, b;
    logic [1:0]   s;
    logic         m;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered just after a negedge with the request driven; counts cycles to ready.
  task automatic wait_ready(output logic [127:0] res, output int cyc);
    cyc = 0;
    res = '0;
    while (1) begin
      #1;
      if (ready) break;
      if (cyc >= 300) break;
      @(negedge clk);
      cyc++;
    end
    res = mul_result;
    @(negedge clk);
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] s, input logic m);
    rs1_data   = a;
    rs2_data   = b;
    mul_signed = s;
    mul_32     = m;
    valid      = 1'b1;
  endtask

  initial begin
    logic [127:0] res;
    int           cyc;
    logic         stall_bad;

    vecs[0]  = '{"zero_fast",   64'h1234_5678_9ABC_DEF0, 64'h0, MUL_SIGNED_SS, 1'b0, 128'h0, 0};
    vecs[1]  = '{"mulhu_ones",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, MUL_SIGNED_UU, 1'b0,
                 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 66};
    vecs[2]  = '{"mulh_m1",     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, MUL_SIGNED_SS, 1'b0,
                 128'h1, 66};
    vecs[3]  = '{"mulhsu_m1",   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, MUL_SIGNED_SU, 1'b0,
                 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001, 66};
    vecs[4]  = '{"mulw_max2",   64'hDEAD_0000_7FFF_FFFF, 64'h2, MUL_SIGNED_SS, 1'b1,
                 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFE, 34};
    vecs[5]  = '{"mul_3x5",     64'h3, 64'h5, MUL_SIGNED_SS, 1'b0, 128'hF, 66};
    vecs[6]  = '{"mul_m2x3",    64'hFFFF_FFFF_FFFF_FFFE, 64'h3, MUL_SIGNED_SS, 1'b0,
                 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA, 66};
    vecs[7]  = '{"mulh_minmin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, MUL_SIGNED_SS, 1'b0,
                 128'h4000_0000_0000_0000_0000_0000_0000_0000, 66};
    vecs[8]  = '{"mulhu_2p64",  64'h8000_0000_0000_0000, 64'h2, MUL_SIGNED_UU, 1'b0,
                 128'h0000_0000_0000_0001_0000_0000_0000_0000, 66};
    vecs[9]  = '{"mulw_zero",   64'hFFFF_FFFF_0000_0000, 64'h5, MUL_SIGNED_SS, 1'b1, 128'h0, 0};
    vecs[10] = '{"mulw_m3x7",   64'h0000_0000_FFFF_FFFD, 64'h7, MUL_SIGNED_SS, 1'b1,
                 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFEB, 34};
    vecs[11] = '{"mulw_wrap",   64'h0001_0000, 64'h0001_0000, MUL_SIGNED_SS, 1'b1, 128'h0, 34};
    vecs[12] = '{"mulw_uu",     64'hFFFF_FFFF, 64'hFFFF_FFFF, MUL_SIGNED_UU, 1'b1, 128'h1, 34};
    vecs[13] = '{"mulhsu_m2x3", 64'hFFFF_FFFF_FFFF_FFFE, 64'h3, MUL_SIGNED_SU, 1'b0,
                 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA, 66};
    vecs[14] = '{"zero_rs1",    64'h0, 64'hFFFF_FFFF_FFFF_FFFF, MUL_SIGNED_UU, 1'b0, 128'h0, 0};

    rst = 1'b1; valid = 1'b0; mul_32 = 1'b0; mul_signed = 2'b00;
    rs1_data = '0; rs2_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 128'(ready), 128'h0);
    chk("reset_result", mul_result, 128'h0);

    // Table runs back-to-back with valid held high between requests.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m);
      wait_ready(res, cyc);
      chk({vecs[i].name, "_res"}, res, vecs[i].exp);
      chk({vecs[i].name, "_lat"}, 128'(cyc), 128'(vecs[i].lat));
    end
    valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ready", 128'(ready), 128'h0);

    // Stall at counter 20 for 5 cycles; operands scrambled mid-flight must be ignored.
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, MUL_SIGNED_UU, 1'b0);
    repeat (20) @(negedge clk);
    valid = 1'b0;
    rs1_data = 64'h0123_4567_89AB_CDEF; rs2_data = 64'h0; mul_signed = MUL_SIGNED_SS; mul_32 = 1'b1;
    stall_bad = 1'b0;
    repeat (5) begin
      #1;
      if (ready) stall_bad = 1'b1;
      @(negedge clk);
    end
    chk("stall_no_ready", 128'(stall_bad), 128'h0);
    valid = 1'b1;
    wait_ready(res, cyc);
    chk("stall_res", res, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    chk("stall_lat", 128'(cyc + 25), 128'd71);
    valid = 1'b0;
    @(negedge clk);

    // Reset at counter 30, then a fresh request must run a full 66 cycles.
    drive(64'h3, 64'h5, MUL_SIGNED_SS, 1'b0);
    repeat (30) @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready", 128'(ready), 128'h0);
    chk("rst_mid_result", mul_result, 128'h0);
    @(negedge clk);
    drive(64'hFFFF_FFFF_FFFF_FFFE, 64'h3, MUL_SIGNED_SS, 1'b0);
    wait_ready(res, cyc);
    chk("post_rst_res", res, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA);
    chk("post_rst_lat", 128'(cyc), 128'd66);
    valid = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
